counter_scheduler: RTL and testbench

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

---
 rtl/counter_scheduler.sv | 153 +++++++++++++++
 tb/tb_counter_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin owner of one shared up/down counter; grant and enable one edge after req, done one cycle after the last step.
// Requester holds req until its done pulse (drop = abort). Optional clear per requester with macro COUNTER_SCHEDULER_CLEAR_EN.
module counter_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int STEP_WIDTH = 8,
  parameter int WIDTH      = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            reqDirection,
  input  logic [NUM_REQ*STEP_WIDTH-1:0] reqSteps,
`ifdef COUNTER_SCHEDULER_CLEAR_EN
  input  logic [NUM_REQ-1:0]            reqClear,
`endif
  input  logic [WIDTH-1:0]              counterValue,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [WIDTH-1:0]              resultValue,
  output logic                          counterEnable,
  output logic                          counterDirection,
  output logic                          counterReset,
  output logic                          busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         ptr, ptr_nxt;
  logic [IW-1:0]         owner, owner_nxt;
  logic [STEP_WIDTH-1:0] remain, remain_nxt;
  logic                  clr_q, clr_nxt;
  logic [NUM_REQ-1:0]    grant_nxt, done_nxt;
  logic [WIDTH-1:0]      result_nxt;
  logic                  en_nxt, dir_nxt, rst_nxt, busy_nxt;

  logic [NUM_REQ-1:0]    clr_vec;
  logic [IW-1:0]         win;
  logic [IW-1:0]         idx;
  logic [STEP_WIDTH-1:0] win_steps;

`ifdef COUNTER_SCHEDULER_CLEAR_EN
  assign clr_vec = reqClear;
`else
  assign clr_vec = '0;
`endif

  // Scan from the pointer downwards so the closest requester at or after it wins.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) win = idx;
    end
  end

  assign win_steps = reqSteps[int'(win)*STEP_WIDTH +: STEP_WIDTH];

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    owner_nxt  = owner;
    remain_nxt = remain;
    clr_nxt    = clr_q;
    grant_nxt  = grant;
    done_nxt   = '0;
    en_nxt     = counterEnable;
    dir_nxt    = counterDirection;
    rst_nxt    = 1'b0;
    result_nxt = resultValue;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt      = win;
          dir_nxt        = reqDirection[win];
          remain_nxt     = win_steps;
          clr_nxt        = clr_vec[win];
          grant_nxt      = '0;
          grant_nxt[win] = 1'b1;
          if (clr_vec[win]) begin
            state_nxt = RUN;
            rst_nxt   = 1'b1;
            en_nxt    = 1'b0;
          end else if (win_steps == '0) begin
            state_nxt     = DONE;
            grant_nxt     = '0;
            done_nxt[win] = 1'b1;
            en_nxt        = 1'b0;
          end else begin
            state_nxt = RUN;
            en_nxt    = 1'b1;
          end
        end
      end
      RUN: begin
        if (!req[owner]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          en_nxt    = 1'b0;
        end else if (clr_q || remain == STEP_WIDTH'(1)) begin
          state_nxt       = DONE;
          grant_nxt       = '0;
          en_nxt          = 1'b0;
          done_nxt[owner] = 1'b1;
        end else begin
          remain_nxt = remain - STEP_WIDTH'(1);
        end
      end
      DONE: begin
        // The counter already holds every step here, so sample it on the way out.
        state_nxt  = IDLE;
        result_nxt = counterValue;
        ptr_nxt    = IW'((int'(owner) + 1) % NUM_REQ);
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      ptr              <= '0;
      owner            <= '0;
      remain           <= '0;
      clr_q            <= 1'b0;
      grant            <= '0;
      done             <= '0;
      resultValue      <= '0;
      counterEnable    <= 1'b0;
      counterDirection <= 1'b0;
      counterReset     <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_nxt;
      ptr              <= ptr_nxt;
      owner            <= owner_nxt;
      remain           <= remain_nxt;
      clr_q            <= clr_nxt;
      grant            <= grant_nxt;
      done             <= done_nxt;
      resultValue      <= result_nxt;
      counterEnable    <= en_nxt;
      counterDirection <= dir_nxt;
      counterReset     <= rst_nxt;
      busy             <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: vector table, hand corner sequences and a randomized run against a transaction-level model.
// The shared counter lives here and follows counterEnable/counterDirection/counterReset.
module tb_counter_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  reqDirection = '0;
  logic [31:0] reqSteps = '0;
`ifdef COUNTER_SCHEDULER_CLEAR_EN
  logic [3:0]  reqClear = '0;
`endif
  logic [7:0]  cnt;
  logic [3:0]  grant, done;
  logic [7:0]  resultValue;
  logic        counterEnable, counterDirection, counterReset, busy;

  int errors = 0;
  int checks = 0;
  int last_rst = 0;
  logic clr_mode = 1'b0;
  logic rst_seen = 1'b0;

  counter_scheduler #(.NUM_REQ(4), .STEP_WIDTH(8), .WIDTH(8)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req(req),
    .reqDirection(reqDirection),
    .reqSteps(reqSteps),
`ifdef COUNTER_SCHEDULER_CLEAR_EN
    .reqClear(reqClear),
`endif
    .counterValue(cnt),
    .grant(grant),
    .done(done),
    .resultValue(resultValue),
    .counterEnable(counterEnable),
    .counterDirection(counterDirection),
    .counterReset(counterReset),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)            cnt <= 8'd0;
    else if (counterReset)   cnt <= 8'd0;
    else if (counterEnable)  cnt <= counterDirection ? cnt + 8'd1 : cnt - 8'd1;
  end

`ifndef COUNTER_SCHEDULER_CLEAR_EN
  always @(negedge clock) if (counterReset !== 1'b0) rst_seen = 1'b1;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {12'd0, grant, done, resultValue, counterEnable, counterDirection, counterReset, busy};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req = '0;
    #1 check("reset_outputs", all_outs(), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One request pattern from an IDLE negedge through done and the following IDLE cycle.
  task automatic run_txn(input logic [3:0] r, input logic [3:0] d, input logic [31:0] sv,
                         input logic [3:0] exp_done, input logic [7:0] exp_res,
                         input int exp_en, input string nm);
    int en_cnt = 0, rst_c = 0, dir_bad = 0, n = 0;
    logic [3:0] g_or = '0, dn = '0;
    req = r; reqDirection = d; reqSteps = sv;
    while (dn == 4'd0 && n < 600) begin
      @(negedge clock);
      n++;
      g_or |= grant;
      if (counterEnable) begin
        en_cnt++;
        if (counterDirection !== |(d & exp_done)) dir_bad++;
      end
      if (counterReset) rst_c++;
      dn = done;
    end
    check({nm, "_done"}, {28'd0, dn}, {28'd0, exp_done});
    check({nm, "_en_cycles"}, en_cnt, exp_en);
    check({nm, "_grant"}, {28'd0, g_or}, (exp_en > 0 || clr_mode) ? {28'd0, exp_done} : 32'd0);
    check({nm, "_direction"}, dir_bad, 0);
    last_rst = rst_c;
    req = '0;
    @(negedge clock);
    check({nm, "_result"}, {24'd0, resultValue}, {24'd0, exp_res});
    check({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_done(input string nm, output logic [3:0] dn);
    int n = 0;
    dn = '0;
    while (dn == 4'd0 && n < 200) begin
      @(negedge clock);
      n++;
      dn = done;
    end
    if (dn == 4'd0) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0] r;
    logic [3:0] d;
    logic [7:0] st;
    logic [3:0] exp_done;
    logic [7:0] exp_res;
  } vec_t;

  vec_t tbl[9];
  logic [3:0] dn, rr, dd, g_or;
  logic [31:0] sv;
  logic [7:0] cnt_m;
  int ptr_m, w, s;

  initial begin
    tbl[0] = '{4'b0001, 4'b0001, 8'd5, 4'b0001, 8'd5};
    tbl[1] = '{4'b1001, 4'b0000, 8'd3, 4'b1000, 8'd2};
    tbl[2] = '{4'b1001, 4'b1111, 8'd0, 4'b0001, 8'd2};
    tbl[3] = '{4'b0011, 4'b1111, 8'd4, 4'b0010, 8'd6};
    tbl[4] = '{4'b0011, 4'b0000, 8'd7, 4'b0001, 8'd255};
    tbl[5] = '{4'b1100, 4'b1111, 8'd1, 4'b0100, 8'd0};
    tbl[6] = '{4'b0111, 4'b1111, 8'd2, 4'b0001, 8'd2};
    tbl[7] = '{4'b0010, 4'b0000, 8'd1, 4'b0010, 8'd1};
    tbl[8] = '{4'b0100, 4'b0000, 8'd3, 4'b0100, 8'd254};

    #2 check("por_outputs", all_outs(), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].r, tbl[i].d, {4{tbl[i].st}}, tbl[i].exp_done, tbl[i].exp_res,
              int'(tbl[i].st), $sformatf("vec%0d", i));

    // Contention: 1 then 2 with one IDLE gap, then 3 beats 1.
    do_reset();
    req = 4'b0110; reqDirection = 4'b1111; reqSteps = {4{8'd2}};
    @(negedge clock);
    check("cont_first_grant", {28'd0, grant}, 32'b0010);
    wait_done("cont_a", dn);
    check("cont_first_done", {28'd0, dn}, 32'b0010);
    req = 4'b0100;
    @(negedge clock);
    check("cont_gap_grant", {28'd0, grant}, 32'd0);
    check("cont_gap_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("cont_second_grant", {28'd0, grant}, 32'b0100);
    wait_done("cont_b", dn);
    check("cont_second_done", {28'd0, dn}, 32'b0100);
    req = 4'b1010;
    @(negedge clock);
    check("cont_no_arb_in_done", {28'd0, grant}, 32'd0);
    @(negedge clock);
    check("cont_third_grant", {28'd0, grant}, 32'b1000);
    wait_done("cont_c", dn);
    req = '0;
    @(negedge clock);

    // Abort after two steps: counter keeps the two steps, no done, pointer stays.
    do_reset();
    run_txn(4'b0001, 4'b1111, {4{8'd5}}, 4'b0001, 8'd5, 5, "pre_abort");
    req = 4'b0010; reqDirection = 4'b1111; reqSteps = {4{8'd10}};
    g_or = '0;
    @(negedge clock); g_or |= done;
    @(negedge clock); g_or |= done;
    req = '0;
    @(negedge clock); g_or |= done;
    check("abort_grant", {28'd0, grant}, 32'd0);
    check("abort_enable", {31'd0, counterEnable}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_done", {28'd0, g_or}, 32'd0);
    check("abort_counter", {24'd0, cnt}, 32'd7);
    check("abort_result_kept", {24'd0, resultValue}, 32'd5);
    run_txn(4'b0011, 4'b1111, {4{8'd1}}, 4'b0010, 8'd8, 1, "post_abort_ptr");

    // Asynchronous reset in the middle of a run.
    req = 4'b0010; reqDirection = 4'b1111; reqSteps = {4{8'd20}};
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check("midrun_reset_outputs", all_outs(), 32'd0);
    req = '0;
    @(negedge clock);
    reset_n = 1'b1;
    run_txn(4'b0100, 4'b1111, {4{8'd3}}, 4'b0100, 8'd3, 3, "after_reset");

    // Longest step count.
    do_reset();
    run_txn(4'b0001, 4'b0001, {4{8'd255}}, 4'b0001, 8'd255, 255, "max_steps");

`ifdef COUNTER_SCHEDULER_CLEAR_EN
    do_reset();
    run_txn(4'b0001, 4'b0001, {4{8'd7}}, 4'b0001, 8'd7, 7, "clr_pre");
    reqClear = 4'b1000; clr_mode = 1'b1;
    run_txn(4'b1000, 4'b1111, {4{8'd9}}, 4'b1000, 8'd0, 0, "clear");
    check("clear_reset_cycles", last_rst, 1);
    reqClear = '0; clr_mode = 1'b0;
`endif

    // Randomized run against the transaction-level model.
    do_reset();
    ptr_m = 0;
    cnt_m = 8'd0;
    for (int t = 0; t < 30; t++) begin
      rr = 4'($urandom_range(1, 15));
      dd = 4'($urandom);
      for (int k = 0; k < 4; k++) sv[k*8 +: 8] = 8'($urandom_range(0, 12));
      w = -1;
      for (int k = 0; k < 4; k++) if (w < 0 && rr[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
      s = int'(sv[w*8 +: 8]);
      cnt_m = dd[w] ? cnt_m + 8'(s) : cnt_m - 8'(s);
      run_txn(rr, dd, sv, 4'(1 << w), cnt_m, s, $sformatf("rand%0d", t));
      ptr_m = (w + 1) % 4;
    end

`ifndef COUNTER_SCHEDULER_CLEAR_EN
    check("counterReset_const0", {31'd0, rst_seen}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
